// File: rtl/vga_plot_pkg.sv
// vga_plot_pkg: draw-mode encodings, plotter FSM states and default screen size
package vga_plot_pkg;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam logic [1:0] MODE_FILL    = 2'b00;
  localparam logic [1:0] MODE_OUTLINE = 2'b01;
  localparam logic [1:0] MODE_CLEAR   = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAW, ST_DONE} state_t;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: x-fastest scan over a loaded box; load latches bounds and start, advance steps, outputs next position, bounds and last flag
module raster_counter #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           load,
  input  logic           advance,
  input  logic [X_W-1:0] xs,
  input  logic [Y_W-1:0] ys,
  input  logic [X_W-1:0] xe,
  input  logic [Y_W-1:0] ye,
  output logic [X_W-1:0] nx,
  output logic [Y_W-1:0] ny,
  output logic [X_W-1:0] lo_x,
  output logic [X_W-1:0] hi_x,
  output logic [Y_W-1:0] lo_y,
  output logic [Y_W-1:0] hi_y,
  output logic           last
);
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           row_end;

  assign row_end = cx == hi_x;
  assign last    = row_end && cy == hi_y;
  assign nx      = row_end ? lo_x : cx + X_W'(1);
  assign ny      = row_end ? cy + Y_W'(1) : cy;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cx   <= '0;
      cy   <= '0;
      lo_x <= '0;
      hi_x <= '0;
      lo_y <= '0;
      hi_y <= '0;
    end else if (load) begin
      cx   <= xs;
      cy   <= ys;
      lo_x <= xs;
      hi_x <= xe;
      lo_y <= ys;
      hi_y <= ye;
    end else if (advance) begin
      cx <= nx;
      cy <= ny;
    end
  end
endmodule

// File: rtl/vga_rect_plotter.sv
// vga_rect_plotter: rectangle fill/outline/clear engine; start+mode+cmd_* in, busy/done status out, x/y/colour/plot to vga_adapter
module vga_rect_plotter
  import vga_plot_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [X_W-1:0]      cmd_x0,
  input  logic [Y_W-1:0]      cmd_y0,
  input  logic [X_W-1:0]      cmd_w,
  input  logic [Y_W-1:0]      cmd_h,
  input  logic [COLOUR_W-1:0] cmd_colour,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);
  localparam logic [X_W:0] X_MAX = (X_W+1)'(SCREEN_W - 1);
  localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(SCREEN_H - 1);

  state_t         state, nxt;
  logic [1:0]     mode_q;
  logic [X_W-1:0] x0_q, w_q, xs_n, xe_n, nx, lo_x, hi_x;
  logic [Y_W-1:0] y0_q, h_q, ys_n, ye_n, ny, lo_y, hi_y;
  logic [X_W:0]   x_end;
  logic [Y_W:0]   y_end;
  logic           clr, empty, last, on_edge, pv;
  logic [X_W-1:0] px;
  logic [Y_W-1:0] py;

  // one extra bit so x0+w-1 can exceed the screen without wrapping before the clip
  assign x_end = {1'b0, x0_q} + {1'b0, w_q} - (X_W+1)'(1);
  assign y_end = {1'b0, y0_q} + {1'b0, h_q} - (Y_W+1)'(1);
  assign clr   = mode_q == MODE_CLEAR;
  assign empty = !clr && (w_q == '0 || h_q == '0 || {1'b0, x0_q} > X_MAX || {1'b0, y0_q} > Y_MAX);
  assign xs_n  = clr ? '0 : x0_q;
  assign ys_n  = clr ? '0 : y0_q;
  assign xe_n  = (clr || x_end > X_MAX) ? X_MAX[X_W-1:0] : x_end[X_W-1:0];
  assign ye_n  = (clr || y_end > Y_MAX) ? Y_MAX[Y_W-1:0] : y_end[Y_W-1:0];

  raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_scan (
    .clock   (clock),
    .resetn  (resetn),
    .load    (state == ST_LOAD),
    .advance (state == ST_DRAW && !last),
    .xs      (xs_n),
    .ys      (ys_n),
    .xe      (xe_n),
    .ye      (ye_n),
    .nx      (nx),
    .ny      (ny),
    .lo_x    (lo_x),
    .hi_x    (hi_x),
    .lo_y    (lo_y),
    .hi_y    (hi_y),
    .last    (last)
  );

  // outputs are registered one position ahead: LOAD presents the first pixel, DRAW presents the counter's next one
  assign on_edge = nx == lo_x || nx == hi_x || ny == lo_y || ny == hi_y;
  assign pv      = state == ST_LOAD ? !empty
                 : state == ST_DRAW && !last && (mode_q != MODE_OUTLINE || on_edge);
  assign px      = state == ST_LOAD ? xs_n : nx;
  assign py      = state == ST_LOAD ? ys_n : ny;

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: nxt = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: nxt = empty ? ST_DONE : ST_DRAW;
      ST_DRAW: nxt = last ? ST_DONE : ST_DRAW;
      ST_DONE: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= ST_IDLE;
    else state <= nxt;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      mode_q <= MODE_FILL;
      x0_q   <= '0;
      y0_q   <= '0;
      w_q    <= '0;
      h_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        mode_q <= mode;
        x0_q   <= cmd_x0;
        y0_q   <= cmd_y0;
        w_q    <= cmd_w;
        h_q    <= cmd_h;
        colour <= cmd_colour;
      end
      busy <= nxt != ST_IDLE;
      done <= nxt == ST_DONE;
      plot <= pv;
      if (pv) begin
        x <= px;
        y <= py;
      end
    end
  end
endmodule

// File: tb/tb_vga_rect_plotter.sv
// tb_vga_rect_plotter: randomized and directed rectangle commands checked cycle by cycle against a geometric reference model
module tb_vga_rect_plotter;
  localparam int SW = 160;
  localparam int SH = 120;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] cmd_x0 = '0;
  logic [6:0] cmd_y0 = '0;
  logic [7:0] cmd_w = '0;
  logic [6:0] cmd_h = '0;
  logic [2:0] cmd_colour = '0;
  logic       busy, done, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  int n_cmp = 0;
  int n_bad = 0;
  int last_x = 0;
  int last_y = 0;
  int last_c = 0;

  always #5 clock = ~clock;

  vga_rect_plotter #(
    .SCREEN_W(SW), .SCREEN_H(SH), .X_W(8), .Y_W(7), .COLOUR_W(3)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .mode       (mode),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_colour (cmd_colour),
    .busy       (busy),
    .done       (done),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic noise(input bit strobe);
    start      = strobe ? 1'($urandom_range(0, 1)) : 1'b0;
    mode       = 2'($urandom);
    cmd_x0     = 8'($urandom);
    cmd_y0     = 7'($urandom);
    cmd_w      = 8'($urandom);
    cmd_h      = 7'($urandom);
    cmd_colour = 3'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_plot"}, int'(plot), 0);
    check({tag, "_x"}, int'(x), last_x);
    check({tag, "_y"}, int'(y), last_y);
    check({tag, "_colour"}, int'(colour), last_c);
  endtask

  // abort_at > 0 pulls resetn low during that cycle of the command
  task automatic run_cmd(input int md, input int x0, input int y0, input int w, input int h,
                         input int col, input bit strobe_noise, input int abort_at);
    int xs, ys, xe, ye, wd, n, k, px, py;
    bit outl, exp_plot;
    @(negedge clock);
    mode = 2'(md); cmd_x0 = 8'(x0); cmd_y0 = 7'(y0); cmd_w = 8'(w); cmd_h = 7'(h);
    cmd_colour = 3'(col); start = 1'b1;
    @(posedge clock);
    outl = md == 1;
    xs = 0; ys = 0; xe = 0; ye = 0; wd = 1; n = 0;
    if (md == 2) begin
      xe = SW - 1; ye = SH - 1; wd = SW; n = SW * SH;
    end else if (w != 0 && h != 0 && x0 < SW && y0 < SH) begin
      xs = x0; ys = y0;
      xe = (x0 + w - 1 < SW - 1) ? x0 + w - 1 : SW - 1;
      ye = (y0 + h - 1 < SH - 1) ? y0 + h - 1 : SH - 1;
      wd = xe - xs + 1;
      n = wd * (ye - ys + 1);
    end
    last_c = col;
    for (int i = 1; i <= n + 2; i++) begin
      @(negedge clock);
      if (i == abort_at) begin
        resetn = 1'b0;
        start = 1'b0;
        @(negedge clock);
        last_x = 0; last_y = 0; last_c = 0;
        check_idle("abort");
        resetn = 1'b1;
        return;
      end
      exp_plot = 1'b0;
      if (i >= 2 && i < n + 2) begin
        k = i - 2;
        px = xs + k % wd;
        py = ys + k / wd;
        exp_plot = !outl || px == xs || px == xe || py == ys || py == ye;
        if (exp_plot) begin
          last_x = px;
          last_y = py;
        end
      end
      check("plot", int'(plot), int'(exp_plot));
      check("x", int'(x), last_x);
      check("y", int'(y), last_y);
      check("colour", int'(colour), last_c);
      check("busy", int'(busy), 1);
      check("done", int'(done), int'(i == n + 2));
      noise(strobe_noise);
    end
    start = 1'b0;
    @(negedge clock);
    check_idle("after");
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    resetn = 1'b1;
    run_cmd(0, 10, 20, 2, 2, 3'b100, 1'b0, 0);
    run_cmd(1, 0, 0, 3, 3, 3'b011, 1'b0, 0);
    run_cmd(0, 158, 119, 5, 3, 3'b010, 1'b0, 0);
    run_cmd(0, 30, 40, 0, 5, 3'b111, 1'b0, 0);
    run_cmd(1, 50, 60, 4, 0, 3'b101, 1'b0, 0);
    run_cmd(0, 200, 10, 4, 4, 3'b110, 1'b0, 0);
    run_cmd(3, 5, 5, 3, 2, 3'b001, 1'b0, 0);
    run_cmd(2, 77, 33, 9, 9, 3'b000, 1'b1, 0);
    run_cmd(0, 5, 5, 4, 4, 3'b111, 1'b0, 4);
    run_cmd(1, 155, 115, 8, 8, 3'b110, 1'b0, 0);
    for (int r = 0; r < 40; r++) begin
      int md;
      md = int'($urandom_range(0, 2));
      if (md == 2) md = 3;
      run_cmd(md, int'($urandom_range(0, 255)) % ((r % 4 == 0) ? 256 : 170),
              int'($urandom_range(0, 127)), int'($urandom_range(0, 14)),
              int'($urandom_range(0, 12)), int'($urandom_range(0, 7)), 1'b1, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_rect_plotter.md
Name: vga_rect_plotter

Overview:
- Parametrised pixel-drawing engine that sits between game control logic and vga_adapter.
- Accepts one rectangle command per handshake and drives the adapter's x, y, colour and plot inputs at one pixel per clock.
- Generalises the fixed 160x120, 3-bit-colour setup to any resolution and colour depth.
- Adds three draw modes: fill, outline and full-screen clear, with screen-edge clipping.

Parameters:
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- X_W, 8, x coordinate width; requires 2^X_W >= SCREEN_W.
- Y_W, 7, y coordinate width; requires 2^Y_W >= SCREEN_H.
- COLOUR_W, 3, colour width; equals 3*BITS_PER_COLOUR_CHANNEL of the adapter.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level).
- resetn  in  1  synchronous active-low reset.
- start  in  1  command strobe, sampled only in IDLE.
- mode  in  2  00 fill, 01 outline, 10 clear, 11 reserved (treated as fill).
- cmd_x0  in  X_W  left column.
- cmd_y0  in  Y_W  top row.
- cmd_w  in  X_W  width in pixels.
- cmd_h  in  Y_W  height in pixels.
- cmd_colour  in  COLOUR_W  draw colour.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle completion pulse.
- x  out  X_W  pixel column to adapter.
- y  out  Y_W  pixel row to adapter.
- colour  out  COLOUR_W  pixel colour to adapter.
- plot  out  1  write enable to adapter.

Behaviour:
- Clock and reset: one clock, clock. Reset is synchronous and active-low on resetn.
- Reset values: with resetn low at a rising edge, state=IDLE and busy, done, plot, x, y, colour are all 0. Reset mid-draw aborts immediately; no further plot pulses occur; the frame buffer is left partially drawn.
- States: IDLE -> LOAD -> DRAW -> DONE -> IDLE.
- IDLE: start=1 at edge T captures mode, cmd_* into registers and moves to LOAD. start while busy is ignored, with no queueing.
- LOAD (cycle T+1): computes clipped bounds.
  - Clear mode: xs=0, ys=0, xe=SCREEN_W-1, ye=SCREEN_H-1.
  - Otherwise: xs=x0, ys=y0, xe=min(x0+w-1, SCREEN_W-1), ye=min(y0+h-1, SCREEN_H-1).
  - Sums are computed in X_W+1 / Y_W+1 bits, with no wrap.
  - Empty region (w=0, h=0, x0>=SCREEN_W or y0>=SCREEN_H): go straight to DONE.
- DRAW: raster scan, x fastest, from (xs,ys) to (xe,ye). N=(xe-xs+1)*(ye-ys+1) cycles.
  - Outputs are registered. Scanned position k (k=0..N-1) is presented during cycle T+2+k.
  - plot=1 for every position in fill/clear.
  - In outline mode, plot=1 only when x==xs, x==xe, y==ys or y==ye. colour is always cmd_colour.
- DONE: done=1, plot=0, for exactly one cycle, at T+2+N (T+2 if empty). Then return to IDLE; busy falls the following cycle.
- Inputs and adapter signals:
  - cmd_* changes after acceptance have no effect.
  - x/y hold their last value when plot=0.
  - Every plotted coordinate satisfies x<SCREEN_W and y<SCREEN_H.

Decomposition:
- Package vga_plot_pkg holds:
  - mode encodings MODE_FILL, MODE_OUTLINE, MODE_CLEAR;
  - the state enum;
  - default SCREEN_W/SCREEN_H constants.
- Sub-module raster_counter holds the nested x/y counter with load(xs,ys,xe,ye), advance and last outputs, parametrised by X_W/Y_W.
- The top FSM owns clipping, outline detection and output registers.

Test Plan:
- Fill 2x2 at (10,20), colour 3'b100, start at T -> plot in cycles T+2..T+5 with (10,20),(11,20),(10,21),(11,21), colour 100; done at T+6.
- Outline 3x3 at (0,0) -> 9 scan cycles, 8 plot pulses, (1,1) never plotted; done at T+11.
- Clip: fill x0=158, y0=119, w=5, h=3 -> exactly two plots, (158,119) and (159,119); done at T+4.
- Empty: w=0 -> no plot pulse; done at T+2; busy high at T+1..T+2 only.
- Clear with colour 3'b000 -> 19200 plots; first (0,0), last (159,119); start pulses mid-clear are ignored; done at T+19202.
- Reset: resetn low during the fill at pixel 2 -> next cycle plot=0, busy=0, x=y=0. A new start then executes normally.
